// File: rtl/athos_ip_pkg.sv
// athos_ip_pkg: shared types and constants for the athos_ip scheduler.
//   - op codes NULL / KECCAK / NTT and a legality helper
//   - athos_sched_state_e : scheduler FSM states
//   - athos_sched_rsp_t   : registered response (data, err)
package athos_ip_pkg;

    localparam int unsigned ATHOS_DATA_W = 1600;
    localparam int unsigned ATHOS_OP_W   = 7;

    localparam logic [ATHOS_OP_W-1:0] OP_NULL   = 7'h00;
    localparam logic [ATHOS_OP_W-1:0] OP_KECCAK = 7'h01;
    localparam logic [ATHOS_OP_W-1:0] OP_NTT    = 7'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } athos_sched_state_e;

    typedef struct packed {
        logic [ATHOS_DATA_W-1:0] data;
        logic                    err;
    } athos_sched_rsp_t;

    function automatic logic op_is_legal(input logic [ATHOS_OP_W-1:0] op);
        return (op == OP_KECCAK) || (op == OP_NTT);
    endfunction

endpackage

// File: rtl/athos_rr_arb.sv
// athos_rr_arb: combinational round-robin arbiter.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle (owned by the caller)
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : index of the granted requester (0 when no request)
module athos_rr_arb #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   pos;

    // Walk the requesters starting at the pointer, wrapping once.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= int'(N_REQ)) begin
                pos = pos - int'(N_REQ);
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt_o[pos[IDX_W-1:0]] = 1'b1;
                idx_o                 = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/athos_ip_sched.sv
// athos_ip_sched: round-robin scheduler sharing one athos_ip core among N_REQ
// requesters. One operation in flight; result returned on a valid/ready
// response channel with a one-cycle interrupt on completion.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   req_valid_i/req_ready_o  per-requester request handshake
//   req_op_i/ctrl_i/data_i   per-requester request payload (slice i = requester i)
//   rsp_valid_o/rsp_ready_i  per-requester response handshake
//   rsp_data_o, rsp_err_o    shared response payload
//   core_data_o, core_ctrl_o core operands ({ctrl, op})
//   core_start_o             one-cycle start pulse
//   core_done_i, core_data_i core completion and result
//   intr_o                   one-cycle pulse on entry to RESP
//   busy_o                   high whenever not IDLE
//
// Build option: ATHOS_SCHED_TIMEOUT_EN enables a BUSY watchdog of TIMEOUT_CYC
// cycles that ends the operation with an error response.
//
// state | meaning
// IDLE  | arbitrate, accept one request
// ISSUE | pulse core_start_o
// BUSY  | wait for core_done_i (or watchdog)
// RESP  | present response to the granted requester
module athos_ip_sched
    import athos_ip_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned DATA_W      = ATHOS_DATA_W,
    parameter int unsigned OP_W        = ATHOS_OP_W,
    parameter int unsigned CTRL_W      = 10,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*OP_W-1:0]    req_op_i,
    input  logic [N_REQ*CTRL_W-1:0]  req_ctrl_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic [N_REQ-1:0]         rsp_valid_o,
    input  logic [N_REQ-1:0]         rsp_ready_i,
    output logic [DATA_W-1:0]        rsp_data_o,
    output logic                     rsp_err_o,
    output logic [DATA_W-1:0]        core_data_o,
    output logic [CTRL_W+OP_W-1:0]   core_ctrl_o,
    output logic                     core_start_o,
    input  logic                     core_done_i,
    input  logic [DATA_W-1:0]        core_data_i,
    output logic                     intr_o,
    output logic                     busy_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    athos_sched_state_e state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [CTRL_W+OP_W-1:0] core_ctrl_q, core_ctrl_d;
    logic [DATA_W-1:0]      core_data_q, core_data_d;
    athos_sched_rsp_t       rsp_q, rsp_d;
    logic                   intr_q, intr_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic [OP_W-1:0]   sel_op;
    logic [CTRL_W-1:0] sel_ctrl;
    logic [DATA_W-1:0] sel_data;

    athos_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i (req_valid_i),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign sel_op   = req_op_i[arb_idx*OP_W +: OP_W];
    assign sel_ctrl = req_ctrl_i[arb_idx*CTRL_W +: CTRL_W];
    assign sel_data = req_data_i[arb_idx*DATA_W +: DATA_W];

`ifdef ATHOS_SCHED_TIMEOUT_EN
    logic [31:0] wdog_q, wdog_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        core_ctrl_d = core_ctrl_q;
        core_data_d = core_data_q;
        rsp_d       = rsp_q;
        intr_d      = 1'b0;
`ifdef ATHOS_SCHED_TIMEOUT_EN
        wdog_d      = wdog_q;
`endif
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    grant_d = arb_idx;
                    if (op_is_legal(sel_op)) begin
                        core_ctrl_d = {sel_ctrl, sel_op};
                        core_data_d = sel_data;
                        state_d     = ISSUE;
                    end else begin
                        // Illegal ops never reach the core.
                        rsp_d.data = '0;
                        rsp_d.err  = 1'b1;
                        intr_d     = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            ISSUE: begin
`ifdef ATHOS_SCHED_TIMEOUT_EN
                wdog_d = '0;
`endif
                state_d = BUSY;
            end
            BUSY: begin
                if (core_done_i) begin
                    rsp_d.data = core_data_i;
                    rsp_d.err  = 1'b0;
                    intr_d     = 1'b1;
                    state_d    = RESP;
                end
`ifdef ATHOS_SCHED_TIMEOUT_EN
                // Fires at the end of the TIMEOUT_CYC-th BUSY cycle.
                else if (wdog_q + 32'd1 >= 32'(TIMEOUT_CYC)) begin
                    rsp_d.data = '0;
                    rsp_d.err  = 1'b1;
                    intr_d     = 1'b1;
                    state_d    = RESP;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    if (grant_q == IDX_W'(N_REQ - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = grant_q + IDX_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            grant_q     <= '0;
            core_ctrl_q <= '0;
            core_data_q <= '0;
            rsp_q       <= '0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            core_ctrl_q <= core_ctrl_d;
            core_data_q <= core_data_d;
            rsp_q       <= rsp_d;
            intr_q      <= intr_d;
        end
    end

`ifdef ATHOS_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rsp_valid_o[i] = (state_q == RESP) && (grant_q == IDX_W'(i));
        end
    end

    assign req_ready_o  = (state_q == IDLE) ? arb_gnt : '0;
    assign rsp_data_o   = rsp_q.data;
    assign rsp_err_o    = rsp_q.err;
    assign core_data_o  = core_data_q;
    assign core_ctrl_o  = core_ctrl_q;
    assign core_start_o = (state_q == ISSUE);
    assign intr_o       = intr_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_athos_ip_sched.sv
module tb_athos_ip_sched;

    localparam int N  = 2;
    localparam int DW = 1600;
    localparam int OW = 7;
    localparam int CW = 10;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*OW-1:0]   req_op = '0;
    logic [N*CW-1:0]   req_ctrl = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '0;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [DW-1:0]     core_data_out;
    logic [CW+OW-1:0]  core_ctrl;
    logic              core_start;
    logic              core_done = 1'b0;
    logic [DW-1:0]     core_data_in = '0;
    logic              intr;
    logic              busy;

    int checks = 0;
    int failures = 0;
    int model_rr = 0;
    int intr_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (intr === 1'b1) intr_cnt++;

    athos_ip_sched #(
        .N_REQ(N), .DATA_W(DW), .OP_W(OW), .CTRL_W(CW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_ctrl_i(req_ctrl), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .core_data_o(core_data_out), .core_ctrl_o(core_ctrl),
        .core_start_o(core_start), .core_done_i(core_done),
        .core_data_i(core_data_in), .intr_o(intr), .busy_o(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_state();
        logic [DW-1:0] v;
        v = '0;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic set_req(input int r, input logic [OW-1:0] op,
                           input logic [CW-1:0] ctrl, input logic [DW-1:0] d);
        req_op[r*OW +: OW]   = op;
        req_ctrl[r*CW +: CW] = ctrl;
        req_data[r*DW +: DW] = d;
    endtask

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int model_pick(input logic [N-1:0] vld);
        for (int k = 0; k < N; k++) begin
            if (vld[(model_rr + k) % N]) return (model_rr + k) % N;
        end
        return -1;
    endfunction

    // One full transaction: accept, (issue, busy, done) or illegal, response
    // held for bp cycles, handshake. Other requesters in vld stay asserted.
    task automatic do_txn(input logic [N-1:0] vld, input int lat, input int bp,
                          input bit done_in_issue, input logic [DW-1:0] result);
        int            w;
        int            bad;
        logic [N-1:0]  exp_oh;
        logic [OW-1:0] op;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        bit            legal;
        w = model_pick(vld);
        if (w < 0) w = 0;
        exp_oh = '0;
        exp_oh[w] = 1'b1;
        op   = req_op[w*OW +: OW];
        ctrl = req_ctrl[w*CW +: CW];
        d    = req_data[w*DW +: DW];
        legal = (op == 7'h01) || (op == 7'h02);
        req_valid = vld;
        #1;
        checks++;
        if (req_ready !== exp_oh) begin
            failures++;
            $display("FAIL arb_grant: req_ready=%b required=%b", req_ready, exp_oh);
        end
        tick();
        req_valid[w] = 1'b0;
        if (legal) begin
            checks++;
            if (core_start !== 1'b1 || core_ctrl !== {ctrl, op} || core_data_out !== d || busy !== 1'b1) begin
                failures++;
                $display("FAIL issue: start=%b ctrl=%h data_lo=%h busy=%b required start=1 ctrl=%h data_lo=%h busy=1",
                         core_start, core_ctrl, core_data_out[63:0], busy, {ctrl, op}, d[63:0]);
            end
            checks++;
            if (req_ready !== '0) begin
                failures++;
                $display("FAIL hold_off_issue: req_ready=%b required=00", req_ready);
            end
            core_done = done_in_issue;
            core_data_in = ~result;
            tick();
            core_done = 1'b0;
            checks++;
            if (core_start !== 1'b0 || rsp_valid !== '0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_enter: start=%b rsp_valid=%b busy=%b required 0 00 1",
                         core_start, rsp_valid, busy);
            end
            bad = 0;
            for (int c = 1; c < lat; c++) begin
                tick();
                if (core_start !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL busy_wait: bad_cycles=%0d required=0", bad);
            end
            core_done = 1'b1;
            core_data_in = result;
            tick();
            core_done = 1'b0;
            core_data_in = rnd_state();
            exp_data = result;
            exp_err  = 1'b0;
            checks++;
            if (rsp_valid !== exp_oh || rsp_err !== 1'b0 || rsp_data !== result || intr !== 1'b1) begin
                failures++;
                $display("FAIL resp: valid=%b err=%b data_lo=%h intr=%b required valid=%b err=0 data_lo=%h intr=1",
                         rsp_valid, rsp_err, rsp_data[63:0], intr, exp_oh, result[63:0]);
            end
        end else begin
            exp_data = '0;
            exp_err  = 1'b1;
            checks++;
            if (core_start !== 1'b0 || rsp_valid !== exp_oh || rsp_err !== 1'b1 || rsp_data !== '0 || intr !== 1'b1) begin
                failures++;
                $display("FAIL illegal_resp: start=%b valid=%b err=%b data_lo=%h intr=%b required start=0 valid=%b err=1 data=0 intr=1",
                         core_start, rsp_valid, rsp_err, rsp_data[63:0], intr, exp_oh);
            end
        end
        rsp_ready = ~exp_oh;
        bad = 0;
        for (int c = 0; c < bp; c++) begin
            tick();
            if (rsp_valid !== exp_oh || rsp_data !== exp_data || rsp_err !== exp_err ||
                intr !== 1'b0 || req_ready !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL resp_hold: unstable_cycles=%0d required=0", bad);
        end
        rsp_ready = exp_oh;
        tick();
        rsp_ready = '0;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== '0 || intr !== 1'b0) begin
            failures++;
            $display("FAIL release: busy=%b rsp_valid=%b intr=%b required 0 00 0", busy, rsp_valid, intr);
        end
        model_rr = (w + 1) % N;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_err !== 1'b0 || core_start !== 1'b0 ||
            intr !== 1'b0 || busy !== 1'b0 || rsp_data !== '0 || core_data_out !== '0 || core_ctrl !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b start=%b intr=%b busy=%b ctrl=%h required all zero",
                     req_ready, rsp_valid, rsp_err, core_start, intr, busy, core_ctrl);
        end
        rst_n = 1'b1;
        model_rr = 0;
        tick();
    endtask

    task automatic test_single_keccak();
        int i0;
        set_req(0, 7'h01, 10'h001, '0);
        i0 = intr_cnt;
        do_txn(2'b01, 24, 1, 1'b0, {200{8'hA5}});
        checks++;
        if (core_ctrl !== 17'h00081) begin
            failures++;
            $display("FAIL keccak_ctrl: core_ctrl=%h required=00081", core_ctrl);
        end
        checks++;
        if (intr_cnt - i0 != 1) begin
            failures++;
            $display("FAIL keccak_intr_count: pulses=%0d required=1", intr_cnt - i0);
        end
    endtask

    task automatic test_contention();
        test_reset();
        set_req(0, 7'h02, 10'h155, rnd_state());
        set_req(1, 7'h01, 10'h2AA, rnd_state());
        do_txn(2'b11, 3, 0, 1'b0, rnd_state());
        do_txn(2'b11, 2, 0, 1'b0, rnd_state());
        do_txn(2'b11, 4, 0, 1'b1, rnd_state());
        req_valid = '0;
    endtask

    task automatic test_illegal();
        set_req(1, 7'h00, 10'h3FF, rnd_state());
        do_txn(2'b10, 1, 2, 1'b0, '0);
        set_req(1, 7'h01, 10'h000, '0);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_oh;
        int w;
        set_req(0, 7'h01, 10'h0F0, rnd_state());
        set_req(1, 7'h02, 10'h00F, rnd_state());
        do_txn(2'b11, 5, 10, 1'b0, rnd_state());
        w = model_pick(req_valid);
        exp_oh = '0;
        if (w >= 0) exp_oh[w] = 1'b1;
        #1;
        checks++;
        if (req_ready !== exp_oh) begin
            failures++;
            $display("FAIL accept_after_handshake: req_ready=%b required=%b", req_ready, exp_oh);
        end
        do_txn(req_valid, 2, 0, 1'b0, rnd_state());
        req_valid = '0;
    endtask

    task automatic test_reset_mid_busy();
        set_req(0, 7'h02, 10'h123, rnd_state());
        set_req(1, 7'h02, 10'h321, rnd_state());
        req_valid = 2'b11;
        tick();
        req_valid = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || core_start !== 1'b0 || intr !== 1'b0 ||
            busy !== 1'b0 || core_ctrl !== '0 || core_data_out !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_busy: valid=%b start=%b intr=%b busy=%b ctrl=%h required all zero",
                     rsp_valid, core_start, intr, busy, core_ctrl);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        model_rr = 0;
        core_done = 1'b1;
        core_data_in = rnd_state();
        tick();
        core_done = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== '0 || intr !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL late_done_ignored: valid=%b intr=%b busy=%b required 00 0 0", rsp_valid, intr, busy);
        end
        do_txn(2'b11, 2, 0, 1'b0, rnd_state());
        req_valid = '0;
    endtask

`ifdef ATHOS_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        set_req(0, 7'h01, 10'h001, rnd_state());
        req_valid = '0;
        req_valid[model_rr] = 1'b1;
        set_req(model_rr, 7'h01, 10'h001, rnd_state());
        tick();
        req_valid = '0;
        n = 0;
        while (rsp_valid === '0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != TO + 1 || rsp_err !== 1'b1 || rsp_data !== '0 || intr !== 1'b1) begin
            failures++;
            $display("FAIL timeout: cycles_after_start=%0d err=%b intr=%b required cycles=%0d err=1 intr=1",
                     n, rsp_err, intr, TO + 1);
        end
        rsp_ready = rsp_valid;
        tick();
        rsp_ready = '0;
        model_rr = (model_rr + 1) % N;
    endtask
`endif

    task automatic test_random();
        logic [OW-1:0] op;
        logic [N-1:0]  vld;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                case ($urandom_range(0, 4))
                    0: op = 7'h00;
                    1: op = 7'h01;
                    2: op = 7'h02;
                    3: op = 7'($urandom_range(3, 127));
                    default: op = 7'h01;
                endcase
                set_req(r, op, 10'($urandom()), rnd_state());
            end
            vld = 2'($urandom_range(1, 3));
            do_txn(vld, $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rnd_state());
            req_valid = '0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        test_reset();
        test_single_keccak();
        test_contention();
        test_illegal();
        test_backpressure();
        test_reset_mid_busy();
`ifdef ATHOS_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/athos_ip_sched.md
# athos_ip_sched

Round-robin scheduler that shares one `athos_ip` accelerator (Keccak-f[1600] / NTT) between `N_REQ` requesters. It accepts one operation at a time, drives the core's data and control inputs, and issues a start. It waits for the core's done status, then returns the 1600-bit result to the owning requester over a valid/ready response channel and pulses an interrupt. It sits between the bus-side register files / DMA ports and the `athos_ip` datapath.

## Interface
- `N_REQ`, 2, number of requesters (≥2)
- `DATA_W`, 1600, state width
- `OP_W`, 7, operation code width
- `CTRL_W`, 10, operation control field width
- `TIMEOUT_CYC`, 4096, watchdog limit in cycles (used only with the macro)
- `clk` in 1: the single clock
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid_i` in N_REQ: per-requester request valid
- `req_ready_o` out N_REQ: per-requester request accept (one-hot or zero)
- `req_op_i` in N_REQ*OP_W: per-requester op code, requester i at slice i
- `req_ctrl_i` in N_REQ*CTRL_W: per-requester control field
- `req_data_i` in N_REQ*DATA_W: per-requester input state
- `rsp_valid_o` out N_REQ: per-requester response valid (one-hot or zero)
- `rsp_ready_i` in N_REQ: per-requester response accept
- `rsp_data_o` out DATA_W: result, shared by all requesters
- `rsp_err_o` out 1: error flag for the current response
- `core_data_o` out DATA_W: to `athos_ip` data input
- `core_ctrl_o` out CTRL_W+OP_W: `{ctrl, op}` to `athos_ip`
- `core_start_o` out 1: one-cycle start pulse
- `core_done_i` in 1: core status done bit
- `core_data_i` in DATA_W: core result
- `intr_o` out 1: one-cycle completion pulse
- `busy_o` out 1: high in any state other than IDLE

## Operation
- FSM has four states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - A round-robin arbiter picks the first valid requester at or after pointer `rr_q`.
  - The winner's `req_ready_o` goes high combinationally in the same cycle.
  - On the handshake, op, ctrl and data are latched, the grant index is registered, and the FSM moves to ISSUE.
- Op validity: ops other than KECCAK (7'h01) and NTT (7'h02), including NULL (7'h00), are illegal.
  - An illegal op goes to RESP with `rsp_err_o`=1 and `rsp_data_o`=0.
  - No `core_start_o` is issued for an illegal op.
- ISSUE:
  - `core_start_o`=1 for exactly one cycle.
  - `core_ctrl_o`/`core_data_o` hold the latched values from ISSUE until the FSM leaves BUSY.
  - Next state is BUSY.
- BUSY:
  - `core_done_i` is sampled only in this state.
  - On done, `core_data_i` is registered into `rsp_data_o`, `rsp_err_o`=0, and the FSM moves to RESP.
- RESP:
  - `rsp_valid_o[grant]`=1 and stays high until `rsp_ready_i[grant]`.
  - `rsp_data_o`/`rsp_err_o` are stable while valid.
  - On the handshake: `rr_q` ← grant+1 mod N_REQ, then IDLE.
- `intr_o` pulses on the cycle the FSM enters RESP.
- `rsp_ready_i` of non-granted requesters is ignored.
- New requests arriving in ISSUE, BUSY or RESP are held off with `req_ready_o`=0.

## Timing
- Reset values:
  - Outputs `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `core_start_o`, `intr_o`, `busy_o` = 0.
  - `rsp_data_o`, `core_data_o`, `core_ctrl_o` = 0.
  - Internal: `rr_q`=0, state=IDLE.
- Latency:
  - Accept at cycle N; start at N+1; BUSY from N+2.
  - Done at cycle M gives `rsp_valid_o` and `intr_o` at M+1.
  - Illegal op: `rsp_valid_o` at N+1.
- The minimum gap between a response handshake and the next request accept is 1 cycle (through IDLE).
- `core_done_i` asserted during ISSUE is ignored; the core must assert it no earlier than the cycle after start.
- `rr_q` wraps from N_REQ-1 to 0.
- Simultaneous requests are resolved by `rr_q` only.
- A requester that drops `req_valid_i` before grant loses no state.
- `rst_n` low in any state returns the FSM to IDLE and clears all outputs asynchronously. Any in-flight result is discarded.

## Configuration
- `ATHOS_SCHED_TIMEOUT_EN` defined:
  - A 32-bit watchdog counter is cleared on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYC` without done, the FSM moves to RESP with `rsp_err_o`=1 and `rsp_data_o`=0.
  - `intr_o` pulses on that transition.
- Undefined: there is no counter, and BUSY waits indefinitely for `core_done_i`.

## Structure
- `athos_ip_pkg` carries:
  - op constants NULL/KECCAK/NTT;
  - `athos_sched_state_e` (IDLE, ISSUE, BUSY, RESP);
  - `athos_sched_rsp_t` (data, err).
- Sub-module `athos_rr_arb`: parameterized `N_REQ` round-robin arbiter.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and index.
  - Purely combinational; the pointer is owned by the scheduler.

## Test plan
- Single KECCAK: requester 0, op 7'h01, ctrl 10'h001, data 0; stub core returns done after 24 cycles with 1600'hA5…A5. Expect:
  - `core_ctrl_o`=17'h00081 and a one-cycle start;
  - `rsp_valid_o`=2'b01 exactly one cycle after done, data A5…A5, err 0;
  - one `intr_o` pulse.
- Contention: both requesters valid in the same cycle from reset → requester 0 served first, requester 1 second, then requester 0 again if it re-requests.
- Illegal op: op 7'h00 from requester 1 → no start pulse; response valid on the next cycle with err=1 and data 0.
- Backpressure: hold `rsp_ready_i` low 10 cycles → valid and data stable, no new accept; accept resumes 1 cycle after the handshake.
- Reset mid-BUSY: assert `rst_n`=0 for 2 cycles → all outputs 0 and IDLE; the late `core_done_i` is ignored.
- With `ATHOS_SCHED_TIMEOUT_EN`, `TIMEOUT_CYC`=16, core never done → error response 16 BUSY cycles after start, `intr_o` pulse.
